// File: rtl/switch_allocator_if.sv
// switch_allocator_if: request, credit and grant/crossbar-select bundle between input channels and the switch allocator
interface switch_allocator_if #(
  parameter int P_CHANNELS     = 5,
  parameter int P_SEL_WIDTH    = 3,
  parameter int P_CREDIT_WIDTH = 3
);
  logic [P_CHANNELS-1:0]                in_sa_enable;
  logic [P_CHANNELS*P_CHANNELS-1:0]     in_sa_request;
  logic [P_CHANNELS*P_CREDIT_WIDTH-1:0] in_credits;
  logic [P_CHANNELS-1:0]                out_sa_grant;
  logic [P_CHANNELS*P_SEL_WIDTH-1:0]    out_xbar_sel;
  logic [P_CHANNELS-1:0]                out_xbar_valid;
  modport master (output in_sa_enable, in_sa_request, in_credits, input out_sa_grant, out_xbar_sel, out_xbar_valid);
  modport slave  (input in_sa_enable, in_sa_request, in_credits, output out_sa_grant, out_xbar_sel, out_xbar_valid);
endinterface

// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin allocator with wormhole hold until the owner drops its request
module switch_allocator #(
  parameter int P_CHANNELS     = 5,
  parameter int P_SEL_WIDTH    = 3,
  parameter int P_CREDIT_WIDTH = 3
) (
  input logic CLK,
  input logic RST,
  switch_allocator_if.slave sa
);
  localparam int P = P_CHANNELS;
  localparam int W = P_SEL_WIDTH;
  logic [P-1:0]   raw, locked, hit, cred_ok, keep, grant;
  logic [P-1:0]   req [P];
  logic [W-1:0]   owner [P], ptr [P], win [P];
  logic [P*W-1:0] sel;
  int idx;
  // keep only the lowest requested output of each enabled input
  always_comb begin
    raw = '0;
    for (int i = 0; i < P; i++) begin
      raw = sa.in_sa_request[i*P +: P] & {P{sa.in_sa_enable[i]}};
      req[i] = '0;
      for (int j = P - 1; j >= 0; j--) if (raw[j]) req[i] = P'(1) << j;
    end
  end
  // descending scan leaves the first requester at or after ptr as winner
  always_comb begin
    idx = 0;
    for (int o = 0; o < P; o++) begin
      win[o] = '0;
      hit[o] = 1'b0;
      cred_ok[o] = |sa.in_credits[o*P_CREDIT_WIDTH +: P_CREDIT_WIDTH];
      keep[o] = req[owner[o]][o];
      for (int k = P - 1; k >= 0; k--) begin
        idx = (int'(ptr[o]) + k) % P;
        if (req[idx][o]) begin
          win[o] = W'(idx);
          hit[o] = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      locked <= '0;
      for (int o = 0; o < P; o++) begin
        owner[o] <= '0;
        ptr[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < P; o++)
        if (locked[o]) locked[o] <= keep[o];
        else if (hit[o] && cred_ok[o]) begin
          locked[o] <= 1'b1;
          owner[o]  <= win[o];
          ptr[o]    <= (win[o] == W'(P - 1)) ? '0 : win[o] + 1'b1;
        end
    end
  always_comb begin
    grant = '0;
    sel = '0;
    for (int o = 0; o < P; o++) begin
      sel[o*W +: W] = locked[o] ? owner[o] : '0;
      for (int i = 0; i < P; i++) grant[i] = grant[i] | (locked[o] && owner[o] == W'(i));
    end
  end
  assign sa.out_sa_grant   = grant;
  assign sa.out_xbar_sel   = sel;
  assign sa.out_xbar_valid = locked;
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: table-driven vectors plus hand sequences for round-robin and mid-lock reset
module tb_switch_allocator;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int errors = 0;
  switch_allocator_if #(.P_CHANNELS(5), .P_SEL_WIDTH(3), .P_CREDIT_WIDTH(3)) sa ();
  switch_allocator #(.P_CHANNELS(5), .P_SEL_WIDTH(3), .P_CREDIT_WIDTH(3)) dut (.CLK(CLK), .RST(RST), .sa(sa));
  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  en;
    logic [24:0] rq;
    logic [14:0] cr;
    logic [4:0]  g;
    logic [4:0]  v;
    logic [14:0] s;
  } vec_t;
  vec_t tbl [18];

  function automatic logic [24:0] slice(input int i, input logic [4:0] v);
    logic [24:0] r;
    r = '0;
    r[i*5 +: 5] = v;
    return r;
  endfunction

  task automatic chk(input string n, input int k, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", n, k, a, e);
    end
  endtask

  task automatic drive(input logic [4:0] en, input logic [24:0] rq, input logic [14:0] cr);
    sa.in_sa_enable  = en;
    sa.in_sa_request = rq;
    sa.in_credits    = cr;
  endtask

  task automatic step(input logic [4:0] en, input logic [24:0] rq, input logic [14:0] cr);
    @(negedge CLK);
    drive(en, rq, cr);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [14:0] c4, cz, c1;
    logic [24:0] par, rr, mix;
    logic [4:0]  rr_en [10];
    logic [4:0]  rr_g  [10];
    logic [2:0]  rr_s  [10];
    c4 = {5{3'd4}};
    cz = c4; cz[5:3] = 3'd0;
    c1 = c4; c1[5:3] = 3'd1;
    par = '0;
    for (int i = 0; i < 5; i++) par = par | slice(i, 5'(1 << (4 - i)));
    for (int k = 0; k < 6; k++) tbl[k] = '{5'b00001, slice(0, 5'b00100), c4, 5'b00001, 5'b00100, 15'd0};
    tbl[6] = '{5'b0, 25'b0, c4, 5'b0, 5'b0, 15'd0};
    for (int k = 7; k < 11; k++) tbl[k] = '{5'b00100, slice(2, 5'b00010), cz, 5'b0, 5'b0, 15'd0};
    tbl[11] = '{5'b00100, slice(2, 5'b00010), c1, 5'b00100, 5'b00010, 15'd16};
    tbl[12] = '{5'b00100, slice(2, 5'b00010), 15'd0, 5'b00100, 5'b00010, 15'd16};
    tbl[13] = '{5'b0, 25'b0, c4, 5'b0, 5'b0, 15'd0};
    tbl[14] = '{5'b01000, slice(3, 5'b10110), c4, 5'b01000, 5'b00010, 15'd24};
    tbl[15] = '{5'b0, 25'b0, c4, 5'b0, 5'b0, 15'd0};
    tbl[16] = '{5'b11111, par, c4, 5'b11111, 5'b11111, 15'd668};
    tbl[17] = '{5'b0, 25'b0, c4, 5'b0, 5'b0, 15'd0};
    rr_en = '{5'b11010, 5'b11010, 5'b11000, 5'b11010, 5'b11010, 5'b10010, 5'b11010, 5'b11010, 5'b01010, 5'b11010};
    rr_g  = '{5'b00010, 5'b00010, 5'b00000, 5'b01000, 5'b01000, 5'b00000, 5'b10000, 5'b10000, 5'b00000, 5'b00010};
    rr_s  = '{3'd1, 3'd1, 3'd0, 3'd3, 3'd3, 3'd0, 3'd4, 3'd4, 3'd0, 3'd1};

    drive(5'b0, 25'b0, c4);
    #2 RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_grant", 0, 32'(sa.out_sa_grant), 0);
    chk("reset_valid", 0, 32'(sa.out_xbar_valid), 0);
    chk("reset_sel", 0, 32'(sa.out_xbar_sel), 0);
    @(negedge CLK) RST = 1'b1;

    for (int k = 0; k < 18; k++) begin
      step(tbl[k].en, tbl[k].rq, tbl[k].cr);
      chk("tbl_grant", k, 32'(sa.out_sa_grant), 32'(tbl[k].g));
      chk("tbl_valid", k, 32'(sa.out_xbar_valid), 32'(tbl[k].v));
      chk("tbl_sel", k, 32'(sa.out_xbar_sel), 32'(tbl[k].s));
    end

    @(negedge CLK) RST = 1'b0;
    @(negedge CLK) RST = 1'b1;
    rr = slice(1, 5'b00001) | slice(3, 5'b00001) | slice(4, 5'b00001);
    for (int k = 0; k < 10; k++) begin
      step(rr_en[k], rr, c4);
      chk("rr_grant", k, 32'(sa.out_sa_grant), 32'(rr_g[k]));
      chk("rr_sel0", k, 32'(sa.out_xbar_sel[2:0]), 32'(rr_s[k]));
      chk("rr_valid0", k, 32'(sa.out_xbar_valid[0]), 32'(rr_g[k] != 0));
    end

    mix = slice(1, 5'b00001) | slice(3, 5'b00100) | slice(4, 5'b01000);
    step(5'b11010, mix, c4);
    chk("mix_grant", 0, 32'(sa.out_sa_grant), 32'b11010);
    chk("mix_valid", 0, 32'(sa.out_xbar_valid), 32'b01101);
    chk("mix_sel", 0, 32'(sa.out_xbar_sel), 2241);
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("async_grant", 0, 32'(sa.out_sa_grant), 0);
    chk("async_valid", 0, 32'(sa.out_xbar_valid), 0);
    chk("async_sel", 0, 32'(sa.out_xbar_sel), 0);
    drive(5'b11010, rr, c4);
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("rearb_grant", 0, 32'(sa.out_sa_grant), 32'b00010);
    chk("rearb_sel", 0, 32'(sa.out_xbar_sel), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
